complex_divider: RTL and testbench



---
 rtl/complex_divider_if.sv | 26 ++
 rtl/complex_divider.sv | 204 ++++++++++++++++++++
 tb/tb_complex_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/complex_divider_if.sv
// complex_divider_if: operand/result bundle between a requester and complex_divider.
// Operands are signed W-bit components; quotient components are signed W+1 bits.
interface complex_divider_if #(
  parameter int unsigned W = 4
);
  logic                ie;
  logic signed [W-1:0] a_r;
  logic signed [W-1:0] a_i;
  logic signed [W-1:0] b_r;
  logic signed [W-1:0] b_i;
  logic signed [W:0]   q_r;
  logic signed [W:0]   q_i;
  logic                done;
  logic                busy;
  logic                dz;

  modport master (
    output ie, a_r, a_i, b_r, b_i,
    input  q_r, q_i, done, busy, dz
  );

  modport slave (
    input  ie, a_r, a_i, b_r, b_i,
    output q_r, q_i, done, busy, dz
  );
endinterface

// File: rtl/complex_divider.sv
// complex_divider: sequential q = a*conj(b)/|b|^2 using one shared multiplier and one restoring divider.
// Define CDIV_ROUND_EN to round quotients to nearest (half away from zero) instead of truncating.
module complex_divider #(
  parameter int unsigned W = 4
) (
  input logic              clk,
  input logic              rst,
  complex_divider_if.slave bus
);
  localparam int unsigned N  = 2 * W + 1;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST_MUL = CW'(5);
  localparam logic [CW-1:0] LAST_DIV = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV_R, DIV_I, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic [N-1:0]        den_q, den_d;
  logic signed [N-1:0] nr_q, nr_d, ni_q, ni_d;
  logic [N-1:0]        dvd_q, dvd_d;
  logic [N-1:0]        rem_q, rem_d;
  logic signed [W:0]   qr_res_q, qr_res_d, qi_res_q, qi_res_d;
  logic signed [W:0]   q_r_q, q_r_d, q_i_q, q_i_d;
  logic                done_q, done_d, busy_q, busy_d, dz_q, dz_d;

  logic signed [W-1:0]  mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic signed [N-1:0]  prod_x;
  logic [N:0]           shifted;
  logic                 ge;
  logic [N-1:0]         rem_nx, quo_nx, nr_abs, ni_abs;
  logic                 rnd_inc;

  // Apply optional rounding increment and the numerator sign to a quotient magnitude.
  function automatic logic signed [W:0] finish_q(input logic [N-1:0] mag, input logic inc,
                                                 input logic neg);
    logic [W:0] t;
    t = (W+1)'(mag + N'(inc));
    return $signed(neg ? -t : t);
  endfunction

  // Operand select for the shared multiplier, one partial product per MUL cycle.
  always_comb begin
    mul_a = br_q;
    mul_b = br_q;
    case (cnt_q)
      CW'(1): begin mul_a = bi_q; mul_b = bi_q; end
      CW'(2): begin mul_a = ar_q; mul_b = br_q; end
      CW'(3): begin mul_a = ai_q; mul_b = bi_q; end
      CW'(4): begin mul_a = ai_q; mul_b = br_q; end
      CW'(5): begin mul_a = ar_q; mul_b = bi_q; end
      default: ;
    endcase
  end

  assign prod   = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
  assign prod_x = {prod[PW-1], prod};

  // One restoring-division step: shift in the next dividend bit, subtract den if it fits.
  assign shifted = {rem_q, dvd_q[N-1]};
  assign ge      = shifted >= {1'b0, den_q};
  assign rem_nx  = ge ? N'(shifted - {1'b0, den_q}) : shifted[N-1:0];
  assign quo_nx  = {dvd_q[N-2:0], ge};
  assign nr_abs  = nr_q[N-1] ? -nr_q : nr_q;
  assign ni_abs  = ni_q[N-1] ? -ni_q : ni_q;

`ifdef CDIV_ROUND_EN
  assign rnd_inc = {rem_nx, 1'b0} >= {1'b0, den_q};
`else
  assign rnd_inc = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ar_d     = ar_q;
    ai_d     = ai_q;
    br_d     = br_q;
    bi_d     = bi_q;
    den_d    = den_q;
    nr_d     = nr_q;
    ni_d     = ni_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    qr_res_d = qr_res_q;
    qi_res_d = qi_res_q;
    q_r_d    = q_r_q;
    q_i_d    = q_i_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    busy_d   = (state_q != IDLE);
    case (state_q)
      // busy_q still covers the done cycle, so a request landing there is dropped.
      IDLE: begin
        if (bus.ie && !busy_q) begin
          ar_d    = bus.a_r;
          ai_d    = bus.a_i;
          br_d    = bus.b_r;
          bi_d    = bus.b_i;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        case (cnt_q)
          CW'(0):  den_d = prod_x;
          CW'(1):  den_d = den_q + prod_x;
          CW'(2):  nr_d  = prod_x;
          CW'(3):  nr_d  = nr_q + prod_x;
          CW'(4):  ni_d  = prod_x;
          default: ni_d  = ni_q - prod_x;
        endcase
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_MUL) begin
          cnt_d   = '0;
          dvd_d   = nr_abs;
          rem_d   = '0;
          state_d = DIV_R;
        end
      end
      DIV_R: begin
        rem_d = rem_nx;
        dvd_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIV) begin
          qr_res_d = finish_q(quo_nx, rnd_inc, nr_q[N-1]);
          dvd_d    = ni_abs;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = DIV_I;
        end
      end
      DIV_I: begin
        rem_d = rem_nx;
        dvd_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIV) begin
          qi_res_d = finish_q(quo_nx, rnd_inc, ni_q[N-1]);
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        dz_d    = (den_q == '0);
        q_r_d   = dz_d ? '0 : qr_res_q;
        q_i_d   = dz_d ? '0 : qi_res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ar_q     <= '0;
      ai_q     <= '0;
      br_q     <= '0;
      bi_q     <= '0;
      den_q    <= '0;
      nr_q     <= '0;
      ni_q     <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      qr_res_q <= '0;
      qi_res_q <= '0;
      q_r_q    <= '0;
      q_i_q    <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ar_q     <= ar_d;
      ai_q     <= ai_d;
      br_q     <= br_d;
      bi_q     <= bi_d;
      den_q    <= den_d;
      nr_q     <= nr_d;
      ni_q     <= ni_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      qr_res_q <= qr_res_d;
      qi_res_q <= qi_res_d;
      q_r_q    <= q_r_d;
      q_i_q    <= q_i_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.q_r  = q_r_q;
  assign bus.q_i  = q_i_q;
  assign bus.dz   = dz_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_complex_divider.sv
// tb_complex_divider: directed vector table, protocol corner sequences and random operands
// checked against an integer-arithmetic model of complex division.
module tb_complex_divider;
  localparam int W   = 4;
  localparam int LAT = 25;
`ifdef CDIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    int ar; int ai; int br; int bi;
    int qr; int qi; int dz;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  complex_divider_if #(.W(W)) bus ();

  complex_divider #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer division truncates toward zero; rounding adds one when 2*rem >= den.
  function automatic int ref_div(input int n, input int d);
    int m, r;
    m = (n < 0 ? -n : n) / d;
    r = (n < 0 ? -n : n) % d;
    if (RND != 0 && 2 * r >= d) m++;
    return (n < 0) ? -m : m;
  endfunction

  function automatic vec_t ref_model(input int ar, input int ai, input int br, input int bi);
    vec_t v;
    int den;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
    den = br * br + bi * bi;
    if (den == 0) begin
      v.qr = 0; v.qi = 0; v.dz = 1;
    end else begin
      v.qr = ref_div(ar * br + ai * bi, den);
      v.qi = ref_div(ai * br - ar * bi, den);
      v.dz = 0;
    end
    return v;
  endfunction

  // Called at a negedge; returns at the negedge following the edge that sampled ie.
  task automatic start(input int ar, input int ai, input int br, input int bi);
    bus.ie  = 1'b1;
    bus.a_r = 4'(ar); bus.a_i = 4'(ai); bus.b_r = 4'(br); bus.b_i = 4'(bi);
    @(negedge clk);
    bus.ie  = 1'b0;
    bus.a_r = 4'($urandom); bus.a_i = 4'($urandom);
    bus.b_r = 4'($urandom); bus.b_i = 4'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, bcnt;
    start(v.ar, v.ai, v.br, v.bi);
    wait_done(lat, bcnt);
    check({tag, " latency"}, lat, LAT);
    check({tag, " busy_cycles"}, bcnt, LAT);
    check({tag, " q_r"}, int'(bus.q_r), v.qr);
    check({tag, " q_i"}, int'(bus.q_i), v.qi);
    check({tag, " dz"}, int'(bus.dz), v.dz);
    @(negedge clk);
  endtask

  vec_t tbl[10];

  initial begin
    int ndone, first, second, qr1, qi1, qr2, qi2;
    vec_t v;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    bus.ie = 1'b0;
    bus.a_r = '0; bus.a_i = '0; bus.b_r = '0; bus.b_i = '0;

    tbl[0] = '{6, 4, 1, 1, 5, -1, 0};
    tbl[1] = '{7, 0, 0, 2, 0, (RND != 0) ? -4 : -3, 0};
    tbl[2] = '{-8, -8, 1, 0, -8, -8, 0};
    tbl[3] = '{7, 7, 1, -1, 0, 7, 0};
    tbl[4] = '{-8, -8, -8, -8, 1, 0, 0};
    tbl[5] = '{5, 3, 0, 0, 0, 0, 1};
    tbl[6] = '{4, 2, 2, 0, 2, 1, 0};
    tbl[7] = '{3, 0, 2, 0, (RND != 0) ? 2 : 1, 0, 0};
    tbl[8] = '{-3, 0, 2, 0, (RND != 0) ? -2 : -1, 0, 0};
    tbl[9] = '{7, -8, 3, 1, 1, -3, 0};

    repeat (3) @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset q_r", int'(bus.q_r), 0);
    check("reset q_i", int'(bus.q_i), 0);
    check("reset dz", int'(bus.dz), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Requests during the operation and in the done cycle are dropped; the next cycle is accepted.
    ndone = 0; first = -1; second = -1; qr1 = 0; qi1 = 0; qr2 = 0; qi2 = 0;
    start(6, 4, 1, 1);
    for (int n = 0; n <= 70; n++) begin
      if (bus.done) begin
        if (ndone == 0) begin
          first = n; qr1 = int'(bus.q_r); qi1 = int'(bus.q_i);
        end else begin
          second = n; qr2 = int'(bus.q_r); qi2 = int'(bus.q_i);
        end
        ndone++;
      end
      bus.ie = (n == 5 || n == 25 || n == 26);
      if (n == 26) begin
        bus.a_r = 4'(7); bus.a_i = 4'(7); bus.b_r = 4'(1); bus.b_i = 4'(-1);
      end else begin
        bus.a_r = 4'(7); bus.a_i = 4'(0); bus.b_r = 4'(0); bus.b_i = 4'(2);
      end
      @(negedge clk);
    end
    bus.ie = 1'b0;
    check("busy_ie done_count", ndone, 2);
    check("busy_ie first_at", first, LAT);
    check("busy_ie second_at", second, 2 * LAT + 2);
    check("busy_ie first q_r", qr1, 5);
    check("busy_ie first q_i", qi1, -1);
    check("busy_ie second q_r", qr2, 0);
    check("busy_ie second q_i", qi2, 7);

    // Reset in the middle of an operation, with dz set by the previous result.
    run_vec(tbl[5], "pre_reset dz");
    start(6, 4, 1, 1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", int'(bus.busy), 0);
    check("midrst done", int'(bus.done), 0);
    check("midrst q_r", int'(bus.q_r), 0);
    check("midrst q_i", int'(bus.q_i), 0);
    check("midrst dz", int'(bus.dz), 0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check("midrst stale_done", ndone, 0);
    run_vec(tbl[2], "after_reset");

    // Reset and ie together: reset wins and clears the held result.
    bus.ie = 1'b1; rst = 1'b1;
    bus.a_r = 4'(6); bus.a_i = 4'(4); bus.b_r = 4'(1); bus.b_i = 4'(1);
    @(negedge clk);
    bus.ie = 1'b0; rst = 1'b0;
    check("rst_ie busy", int'(bus.busy), 0);
    check("rst_ie q_r", int'(bus.q_r), 0);
    check("rst_ie q_i", int'(bus.q_i), 0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check("rst_ie no_done", ndone, 0);

    // Random operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      v = ref_model(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                    int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      if ($urandom_range(0, 7) == 0) begin
        v = ref_model(v.ar, v.ai, 0, 0);
      end
      run_vec(v, $sformatf("rand%0d a=(%0d,%0d) b=(%0d,%0d)", i, v.ar, v.ai, v.br, v.bi));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
